// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Provides the machine word type plus the instruction-cache geometry,
// frame record and controller state encoding used by icache and its
// frame array.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Handshake bundles around the instruction cache.
// icache_dp_if  : datapath fetch port (imemREN/imemaddr in, ihit/imemload out).
//                 master = datapath, slave = cache.
// icache_mem_if : memory-controller instruction port (iREN/iaddr out,
//                 iwait/iload in). master = cache, slave = memory.
interface icache_dp_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

interface icache_mem_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport master (output iREN, iaddr, input iwait, iload);
  modport slave  (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_frame_array.sv
// Storage for the 2**IDX_W single-word frames of the instruction cache.
// Ports:
//   CLK         clock
//   clear       synchronous clear of every valid bit (reset or invalidate)
//   we/widx/wtag/wdata  synchronous fill port
//   ridx        asynchronous read index
//   rvalid/rtag/rdata   frame contents at ridx
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output word_t            rdata
);

  localparam int NFRAMES = 2 ** IDX_W;

  logic [NFRAMES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [NFRAMES];
  logic [TAG_W-1:0]   tag_d  [NFRAMES];
  word_t              data_q [NFRAMES];
  word_t              data_d [NFRAMES];

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

  // Fill one frame; clear dominates so a fill racing an invalidate is lost.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[widx] = 1'b1;
      tag_d[widx]   = wtag;
      data_d[widx]  = wdata;
    end
    if (clear) begin
      valid_d = '0;
    end
  end

  // Tags and data need no reset: they are meaningless while valid is low.
  always_ff @(posedge CLK) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only, blocking instruction cache with single-word
// frames.
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   dp          datapath fetch port (slave): combinational hit path
//   mem         memory instruction port (master): one miss at a time
//   inval       invalidate every frame
//   hit_count   saturating count of cycles that returned a hit
//   miss_count  saturating count of misses started
// TAG_W must equal 30-IDX_W so tag, index and byte offset cover 32 bits.
module icache
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic         CLK,
  input  logic         RST,
  icache_dp_if.slave   dp,
  icache_mem_if.master mem,
  input  logic         inval,
  output word_t        hit_count,
  output word_t        miss_count
);

  icache_state_t    state_q, state_d;
  word_t            addr_q, addr_d;
  logic             squash_q, squash_d;
  word_t            hit_cnt_q, hit_cnt_d;
  word_t            miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0] req_tag, rd_tag;
  logic [IDX_W-1:0] req_idx;
  logic             rd_valid, hit, fill_we;
  word_t            rd_data;
  logic             unused_offset;

  assign req_tag       = dp.imemaddr[31:32-TAG_W];
  assign req_idx       = dp.imemaddr[IDX_W+1:2];
  assign unused_offset = ^dp.imemaddr[1:0];

  icache_frame_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK    (CLK),
    .clear  (RST | inval),
    .we     (fill_we),
    .widx   (addr_q[IDX_W+1:2]),
    .wtag   (addr_q[31:32-TAG_W]),
    .wdata  (mem.iload),
    .ridx   (req_idx),
    .rvalid (rd_valid),
    .rtag   (rd_tag),
    .rdata  (rd_data)
  );

  assign hit = (state_q == IDLE) && dp.imemREN && rd_valid && (rd_tag == req_tag);

  // A fill is dropped if this transaction was invalidated earlier (squash),
  // is invalidated right now, or is being aborted by reset.
  assign fill_we = (state_q == FETCH) && !mem.iwait && !squash_q && !inval && !RST;

  assign dp.ihit     = hit;
  assign dp.imemload = hit ? rd_data : '0;
  assign mem.iREN    = (state_q == FETCH);
  assign mem.iaddr   = addr_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // Controller: IDLE serves hits and launches misses; FETCH holds the
  // latched address until memory answers, ignoring the datapath meanwhile.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    squash_d   = squash_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (dp.imemREN) begin
          addr_d  = {dp.imemaddr[31:2], 2'b00};
          state_d = FETCH;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      FETCH: begin
        if (inval) squash_d = 1'b1;
        if (!mem.iwait) begin
          state_d  = IDLE;
          squash_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any fill in flight and zeroes the statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      squash_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      squash_q   <= squash_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written
// multi-cycle corner cases and randomized traffic against a reference model
// that tracks which word address each frame holds.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  inval = 1'b0;
  word_t hit_count, miss_count;

  icache_dp_if  dp ();
  icache_mem_if mem ();

  icache dut (
    .CLK        (CLK),
    .RST        (RST),
    .dp         (dp.slave),
    .mem        (mem.master),
    .inval      (inval),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ren;
    word_t addr;
    logic  inv;
    logic  hit;
    word_t load;
    logic  iren;
    word_t iaddr;
    word_t hc;
    word_t mc;
  } vec_t;

  vec_t vecs[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: per frame, the word address it holds (if any).
  bit [15:0]   m_vld;
  logic [29:0] m_line [16];
  bit          m_pend, m_sq;
  word_t       m_laddr, m_hc, m_mc;

  // Memory responder state.
  bit mem_busy;
  int mem_left;
  int mem_wait_cfg = 2;

  // Values observed in the most recent cycle.
  logic  obs_hit, obs_iren;
  word_t obs_load, obs_iaddr, obs_hc, obs_mc;

  function automatic word_t mem_word(input word_t a);
    word_t w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0040) return 32'h2008_0005;
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input logic ren, input word_t addr, input logic inv,
                              input logic hit, input word_t load, input logic iren,
                              input word_t iaddr, input word_t hc, input word_t mc);
    vec_t v;
    v.ren = ren; v.addr = addr; v.inv = inv; v.hit = hit; v.load = load;
    v.iren = iren; v.iaddr = iaddr; v.hc = hc; v.mc = mc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ren, input word_t addr, input logic inv);
    RST          = rst;
    dp.imemREN   = ren;
    dp.imemaddr  = addr;
    inval        = inv;
  endtask

  task automatic modelReset();
    m_vld   = '0;
    m_pend  = 1'b0;
    m_sq    = 1'b0;
    m_laddr = '0;
    m_hc    = '0;
    m_mc    = '0;
    for (int i = 0; i < 16; i++) m_line[i] = '0;
  endtask

  // One clock cycle: memory responds, outputs are sampled and checked
  // against the model, then the model advances across the edge.
  task automatic cycle();
    logic [29:0] wa;
    int          ix;
    bit          ehit, iren_now, iwait_now, rst_now, inv_now, ren_now;
    word_t       eload;
    if (mem.iREN) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = mem_wait_cfg;
      end
      mem.iwait = (mem_left != 0);
      mem.iload = mem.iwait ? 32'hDEAD_BEEF : mem_word(mem.iaddr);
    end else begin
      mem.iwait = 1'b0;
      mem.iload = 32'hBAD0_BAD0;
    end
    #1;
    wa = dp.imemaddr[31:2];
    ix = int'(wa[3:0]);
    if (m_pend) begin
      ehit = 1'b0;
    end else begin
      ehit = dp.imemREN && m_vld[ix] && (m_line[ix] == wa);
    end
    eload = ehit ? mem_word(dp.imemaddr) : '0;
    obs_hit = dp.ihit; obs_load = dp.imemload; obs_iren = mem.iREN;
    obs_iaddr = mem.iaddr; obs_hc = hit_count; obs_mc = miss_count;
    checkOutput("model ihit", {31'd0, obs_hit}, {31'd0, ehit});
    checkOutput("model imemload", obs_load, eload);
    checkOutput("model iREN", {31'd0, obs_iren}, {31'd0, m_pend});
    checkOutput("model iaddr", obs_iaddr, m_laddr);
    checkOutput("model hit_count", obs_hc, m_hc);
    checkOutput("model miss_count", obs_mc, m_mc);
    iren_now = mem.iREN; iwait_now = mem.iwait; rst_now = RST;
    inv_now = inval; ren_now = dp.imemREN;
    @(posedge CLK);
    if (rst_now) begin
      modelReset();
    end else begin
      if (m_pend) begin
        if (inv_now) m_sq = 1'b1;
        if (!iwait_now) begin
          if (!m_sq) begin
            m_vld[m_laddr[5:2]]  = 1'b1;
            m_line[m_laddr[5:2]] = m_laddr[31:2];
          end
          m_pend = 1'b0;
          m_sq   = 1'b0;
        end
      end else if (ehit) begin
        if (m_hc != '1) m_hc++;
      end else if (ren_now) begin
        m_pend  = 1'b1;
        m_laddr = {wa, 2'b00};
        if (m_mc != '1) m_mc++;
      end
      if (inv_now) m_vld = '0;
    end
    if (rst_now || (iren_now && !iwait_now)) mem_busy = 1'b0;
    else if (iren_now) mem_left--;
    @(negedge CLK);
  endtask

  // Clock until the current fill finishes, bounded.
  task automatic waitIdle(input string name);
    int n = 0;
    while (mem.iREN && n < 20) begin
      cycle();
      n++;
    end
    checkOutput({name, " fill timeout"}, {31'd0, mem.iREN}, 32'd0);
  endtask

  initial begin
    word_t data_b;
    logic [25:0] t;
    data_b = mem_word(32'h440);

    // Cold miss, back-to-back hits, byte offset, conflict eviction.
    vecs.push_back(mk(0, 32'h00,  0, 0, 0,            0, 32'h00,  0, 0));
    vecs.push_back(mk(1, 32'h40,  0, 0, 0,            0, 32'h00,  0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h40, 0, 0, 0,           1, 32'h40,  0, 1));
    vecs.push_back(mk(1, 32'h40,  0, 1, 32'h2008_0005, 0, 32'h40, 0, 1));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(1, 32'h40, 0, 1, 32'h2008_0005, 0, 32'h40, i, 1));
    vecs.push_back(mk(1, 32'h43,  0, 1, 32'h2008_0005, 0, 32'h40, 5, 1));
    vecs.push_back(mk(1, 32'h440, 0, 0, 0,            0, 32'h40,  6, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h440, 0, 0, 0,          1, 32'h440, 6, 2));
    vecs.push_back(mk(1, 32'h440, 0, 1, data_b,       0, 32'h440, 6, 2));
    vecs.push_back(mk(1, 32'h40,  0, 0, 0,            0, 32'h440, 7, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h40, 0, 0, 0,           1, 32'h40,  7, 3));
    vecs.push_back(mk(1, 32'h40,  0, 1, 32'h2008_0005, 0, 32'h40, 7, 3));
    vecs.push_back(mk(0, 32'h40,  0, 0, 0,            0, 32'h40,  8, 3));

    applyStimulus(1, 0, 0, 0);
    mem.iwait = 1'b0;
    mem.iload = '0;
    mem_busy  = 1'b0;
    modelReset();
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);

    mem_wait_cfg = 2;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].ren, vecs[i].addr, vecs[i].inv);
      cycle();
      checkOutput($sformatf("vec %0d ihit", i), {31'd0, obs_hit}, {31'd0, vecs[i].hit});
      checkOutput($sformatf("vec %0d imemload", i), obs_load, vecs[i].load);
      checkOutput($sformatf("vec %0d iREN", i), {31'd0, obs_iren}, {31'd0, vecs[i].iren});
      checkOutput($sformatf("vec %0d iaddr", i), obs_iaddr, vecs[i].iaddr);
      checkOutput($sformatf("vec %0d hit_count", i), obs_hc, vecs[i].hc);
      checkOutput($sformatf("vec %0d miss_count", i), obs_mc, vecs[i].mc);
    end

    // Invalidate during FETCH: fill is dropped and the request re-misses.
    applyStimulus(1, 0, 0, 0);
    cycle();
    mem_wait_cfg = 3;
    applyStimulus(0, 1, 32'h80, 0);
    cycle();
    checkOutput("inval miss ihit", {31'd0, obs_hit}, 32'd0);
    checkOutput("inval miss count0", obs_mc, 32'd0);
    cycle();
    checkOutput("inval fetch iREN", {31'd0, obs_iren}, 32'd1);
    checkOutput("inval fetch iaddr", obs_iaddr, 32'h80);
    checkOutput("inval fetch count1", obs_mc, 32'd1);
    applyStimulus(0, 1, 32'h80, 1);
    cycle();
    applyStimulus(0, 1, 32'h80, 0);
    cycle();
    cycle();
    checkOutput("inval last fetch iREN", {31'd0, obs_iren}, 32'd1);
    cycle();
    checkOutput("inval remiss ihit", {31'd0, obs_hit}, 32'd0);
    checkOutput("inval remiss iREN", {31'd0, obs_iren}, 32'd0);
    cycle();
    checkOutput("inval remiss count2", obs_mc, 32'd2);
    waitIdle("inval");
    cycle();
    checkOutput("inval refill ihit", {31'd0, obs_hit}, 32'd1);
    checkOutput("inval refill data", obs_load, mem_word(32'h80));

    // Address change mid-miss: latched address is held until the fill.
    mem_wait_cfg = 2;
    applyStimulus(0, 1, 32'h100, 0);
    cycle();
    checkOutput("addrchg miss ihit", {31'd0, obs_hit}, 32'd0);
    applyStimulus(0, 1, 32'h104, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput($sformatf("addrchg fetch %0d iaddr", i), obs_iaddr, 32'h100);
    end
    cycle();
    checkOutput("addrchg 104 ihit", {31'd0, obs_hit}, 32'd0);
    waitIdle("addrchg");
    applyStimulus(0, 1, 32'h100, 0);
    cycle();
    checkOutput("addrchg 100 ihit", {31'd0, obs_hit}, 32'd1);
    checkOutput("addrchg 100 data", obs_load, mem_word(32'h100));

    // Reset mid-FETCH aborts the fill.
    mem_wait_cfg = 3;
    applyStimulus(0, 1, 32'h200, 0);
    cycle();
    cycle();
    checkOutput("rstmid fetch iREN", {31'd0, obs_iren}, 32'd1);
    applyStimulus(1, 1, 32'h200, 0);
    cycle();
    applyStimulus(0, 1, 32'h200, 0);
    cycle();
    checkOutput("rstmid iREN", {31'd0, obs_iren}, 32'd0);
    checkOutput("rstmid ihit", {31'd0, obs_hit}, 32'd0);
    checkOutput("rstmid hit_count", obs_hc, 32'd0);
    checkOutput("rstmid miss_count", obs_mc, 32'd0);
    cycle();
    checkOutput("rstmid remiss iREN", {31'd0, obs_iren}, 32'd1);
    checkOutput("rstmid remiss count", obs_mc, 32'd1);
    waitIdle("rstmid");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: t = 26'd0;
        1: t = 26'd1;
        2: t = 26'd2;
        default: t = 26'h3FF_FFFF;
      endcase
      mem_wait_cfg = $urandom_range(0, 3);
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                    ($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache.
- Acts as the responder to the datapath's instruction-fetch request (imemREN/imemaddr in; ihit/imemload out).
- Acts as the initiator toward the memory controller's instruction port (iREN/iaddr out; iwait/iload in).
- Single-word blocks; blocking: at most one outstanding miss.

Parameters:
- IDX_W, 4, set index width; number of frames is 2**IDX_W.
- TAG_W, 26, tag width; must equal 30-IDX_W.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word is valid on imemload this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iREN  out  1  read request to memory.
- iaddr  out  32  word-aligned memory address.
- iwait  in  1  memory busy; iload is valid in the cycle iwait=0 while iREN=1.
- iload  in  32  memory read data.
- inval  in  1  invalidate all frames.
- hit_count  out  32  requests satisfied by a hit.
- miss_count  out  32  misses started.

Behaviour:
- Reset (RST=1 at a clock edge):
  - All valid bits cleared; state goes to IDLE.
  - Latched miss address cleared; squash flag cleared; counters go to 0.
  - Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Reset during FETCH aborts the fill; no frame is written.
- Address split: tag=imemaddr[31:32-TAG_W], idx=imemaddr[IDX_W+1:2].
- IDLE state:
  - ihit=imemREN & valid[idx] & (tag[idx]==tag). This is combinational, so a hit has zero added latency.
  - imemload=data[idx] when ihit=1, else 0.
  - iREN=0; iaddr=latched address.
  - imemREN=1 & !hit: latch {imemaddr[31:2],2'b00}; miss_count+1; go to FETCH next cycle.
  - imemREN=0: no action.
- FETCH state:
  - ihit=0; imemload=0; iREN=1; iaddr=latched address.
  - iwait=1: stay in FETCH.
  - iwait=0: write frame[latched idx] with valid=1, tag=latched tag, data=iload (unless squashed); go to IDLE.
  - The hit is presented in the following IDLE cycle, so miss latency = memory wait cycles + 2.
  - Changes to imemaddr or imemREN during FETCH are ignored. The fill completes for the latched address; IDLE then re-evaluates the current request.
- hit_count increments on each cycle with ihit=1.
- Both counters saturate at 32'hFFFF_FFFF.
- Invalidate:
  - inval=1 in IDLE: all valid bits cleared at the edge. ihit in that same cycle still reflects the pre-clear state.
  - inval=1 in FETCH: valid bits cleared and the squash flag is set. The transaction runs until iwait=0, then returns to IDLE without writing the frame. The squash flag clears on leaving FETCH.
- Simultaneous events:
  - inval and fill completion in the same cycle: the frame is not written.
  - RST overrides everything.
- Zero-latency memory (iwait=0 on the first FETCH cycle): fill in that cycle; FETCH lasts exactly one cycle.
- No write path; the instruction stream is read-only.

Decomposition:
- Shared cpu_types_pkg gains:
  - ICACHE_IDX_W (default 4).
  - icache_frame_t struct {logic valid; logic [TAG_W-1:0] tag; word_t data;}.
  - icache_state_t enum {IDLE, FETCH}.
- Reuse word_t from cpu_types_pkg.
- One natural sub-module, icache_frame_array:
  - Holds the 2**IDX_W frames.
  - Async read port (idx); sync write port (we, idx, tag, data).
  - Sync clear-all input driven by RST|inval.
- The FSM and counters stay in icache.

Test Plan:
- Cold miss, memory with 2 wait cycles: reset, then imemREN=1, imemaddr=0x0000_0040, iload=0x2008_0005.
  - Required: iREN=1 and iaddr=0x40 for 3 cycles; ihit=1 with imemload=0x2008_0005 on the next cycle.
  - Required: miss_count=1, hit_count=1.
- Back-to-back hit after the fill above: addr 0x40 for 4 cycles.
  - Required: ihit=1 every cycle, iREN=0, hit_count=5.
- Conflict eviction: fill 0x40 (data A), then request 0x440 (same idx=0, different tag, data B).
  - Required: miss on 0x440 returns B; re-request of 0x40 misses again; miss_count=3.
- Invalidate during FETCH: miss on 0x80 with iwait=1 for 3 cycles; pulse inval=1 in cycle 2.
  - Required: FETCH still ends on iwait=0; next IDLE cycle re-misses on 0x80 (ihit=0, miss_count increments).
- Address change mid-miss: miss on 0x100, switch imemaddr to 0x104 while iwait=1.
  - Required: iaddr stays 0x100 until fill; then 0x104 misses.
  - Required: a later request to 0x100 hits.
- Reset mid-FETCH: assert RST for 1 cycle while iREN=1.
  - Required: iREN=0, ihit=0, counters=0 on the next cycle; a following request to the same address misses.
- Byte-offset ignore: request 0x43 after 0x40 is filled.
  - Required: hit with the same data.
